fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined CPU, plus the IF/ID pipeline buffer feeding decode.
- Owns the PC register, the PC+2 adder, and the branch-redirect mux.
- Presents the PC to instruction memory and registers the returned instruction and next-PC into the IF/ID buffer. The buffer honours hold from the hazard unit and flush from branch control.
- Detects HALT, stops the PC, and drains the pipeline into a terminal halted state.

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch-stage signals: instruction-memory port, branch/hazard
// controls coming back from later stages, and the IF/ID buffer outputs.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_instr;
  logic                   branch_taken;
  logic [ADDR_WIDTH-1:0]  branch_target;
  logic                   hazard_hold;
  logic [INSTR_WIDTH-1:0] id_instruction;
  logic [ADDR_WIDTH-1:0]  id_pc_next;
  logic                   id_valid;
  logic                   pc_stop;
  logic                   halted;

  // The fetch stage itself.
  modport master (
    output imem_addr, id_instruction, id_pc_next, id_valid, pc_stop, halted,
    input  imem_instr, branch_taken, branch_target, hazard_hold
  );

  // Memory, EX branch control, hazard unit and decode as seen from outside.
  modport slave (
    input  imem_addr, id_instruction, id_pc_next, id_valid, pc_stop, halted,
    output imem_instr, branch_taken, branch_target, hazard_hold
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC register, PC+increment adder, branch
// redirect and the IF/ID pipeline buffer. A fetched HALT freezes the PC and
// the stage then drains a fixed number of unheld cycles into a terminal
// halted state; a branch arriving before that cancels the (wrong-path) HALT.
module fetch_stage #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    INSTR_WIDTH  = 16,
  parameter int                    PC_INCR      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = 16'h0000,
  parameter logic [3:0]            HALT_OPCODE  = 4'hF,
  parameter int                    DRAIN_CYCLES = 3
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
);

  // Counter only needs to hold DRAIN_CYCLES down to zero.
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  w_pc_nxt;
  logic [ADDR_WIDTH-1:0]  w_pc_plus;
  logic [ADDR_WIDTH-1:0]  w_target;
  logic [INSTR_WIDTH-1:0] r_id_instr;
  logic [INSTR_WIDTH-1:0] w_id_instr_nxt;
  logic [ADDR_WIDTH-1:0]  r_id_pc_next;
  logic [ADDR_WIDTH-1:0]  w_id_pc_next_nxt;
  logic                   r_id_valid;
  logic                   w_id_valid_nxt;
  logic [CNT_W-1:0]       r_drain_cnt;
  logic [CNT_W-1:0]       w_drain_cnt_nxt;
  logic                   w_is_halt;

  // Sequential increment wraps naturally at the top of the address space.
  assign w_pc_plus = r_pc + ADDR_WIDTH'(PC_INCR);
  // Instructions are halfword aligned, so the redirect address drops bit 0.
  assign w_target  = bus.branch_target & ~ADDR_WIDTH'(1);
  assign w_is_halt = (bus.imem_instr[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  // Next-state, next-PC and IF/ID buffer selection; priority is branch, then hold, then fetch.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_id_instr_nxt   = r_id_instr;
    w_id_pc_next_nxt = r_id_pc_next;
    w_id_valid_nxt   = r_id_valid;
    w_drain_cnt_nxt  = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (bus.branch_taken) begin
          // Redirect; whatever memory returned this cycle is wrong-path.
          w_pc_nxt         = w_target;
          w_id_instr_nxt   = {INSTR_WIDTH{1'b0}};
          w_id_pc_next_nxt = {ADDR_WIDTH{1'b0}};
          w_id_valid_nxt   = 1'b0;
        end else if (bus.hazard_hold) begin
          w_state_nxt = r_state;
        end else begin
          w_id_instr_nxt   = bus.imem_instr;
          w_id_pc_next_nxt = w_pc_plus;
          w_id_valid_nxt   = 1'b1;
          if (w_is_halt) begin
            // PC parks on the HALT; start draining the younger stages.
            w_state_nxt     = ST_HALT_PEND;
            w_drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
          end else begin
            w_pc_nxt = w_pc_plus;
          end
        end
      end
      ST_HALT_PEND: begin
        if (bus.branch_taken) begin
          // The HALT was on a mispredicted path: resume normal fetch.
          w_state_nxt      = ST_RUN;
          w_pc_nxt         = w_target;
          w_id_instr_nxt   = {INSTR_WIDTH{1'b0}};
          w_id_pc_next_nxt = {ADDR_WIDTH{1'b0}};
          w_id_valid_nxt   = 1'b0;
          w_drain_cnt_nxt  = {CNT_W{1'b0}};
        end else if (bus.hazard_hold) begin
          w_state_nxt = r_state;
        end else begin
          w_id_instr_nxt   = {INSTR_WIDTH{1'b0}};
          w_id_pc_next_nxt = {ADDR_WIDTH{1'b0}};
          w_id_valid_nxt   = 1'b0;
          w_drain_cnt_nxt  = r_drain_cnt - CNT_W'(1);
          if (r_drain_cnt == CNT_W'(1)) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_state_nxt = ST_HALT_PEND;
          end
        end
      end
      ST_HALTED: begin
        // Terminal: only reset leaves, so branch and hold are ignored.
        w_id_instr_nxt   = {INSTR_WIDTH{1'b0}};
        w_id_pc_next_nxt = {ADDR_WIDTH{1'b0}};
        w_id_valid_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt      = ST_RUN;
        w_pc_nxt         = RESET_PC;
        w_id_instr_nxt   = {INSTR_WIDTH{1'b0}};
        w_id_pc_next_nxt = {ADDR_WIDTH{1'b0}};
        w_id_valid_nxt   = 1'b0;
        w_drain_cnt_nxt  = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, PC, drain counter and IF/ID buffer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_id_instr   <= {INSTR_WIDTH{1'b0}};
      r_id_pc_next <= {ADDR_WIDTH{1'b0}};
      r_id_valid   <= 1'b0;
      r_drain_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_id_instr   <= w_id_instr_nxt;
      r_id_pc_next <= w_id_pc_next_nxt;
      r_id_valid   <= w_id_valid_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
    end
  end

  assign bus.imem_addr      = r_pc;
  assign bus.id_instruction = r_id_instr;
  assign bus.id_pc_next     = r_id_pc_next;
  assign bus.id_valid       = r_id_valid;
  assign bus.pc_stop        = (r_state != ST_RUN);
  assign bus.halted         = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural instruction memory, directed steps
// whose expected IF/ID and status values go into a scoreboard queue when the
// stimulus is driven and are compared after the following clock edge.
module tb_fetch_stage;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcn;
    logic        valid;
    logic        stop;
    logic        halted;
    logic [15:0] addr;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] mem [0:65535];
  exp_t        sb_q [$];
  int          n_compared;
  int          n_mismatched;

  fetch_stage_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) bus ();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational instruction memory.
  assign bus.imem_instr = mem[bus.imem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so a broken design cannot hang the run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "time limit");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_compared++;
    if (obs !== exp_v) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [15:0] e_instr, input logic [15:0] e_pcn,
                          input logic e_valid, input logic e_stop,
                          input logic e_halted, input logic [15:0] e_addr);
    exp_t e;
    e.instr  = e_instr;
    e.pcn    = e_pcn;
    e.valid  = e_valid;
    e.stop   = e_stop;
    e.halted = e_halted;
    e.addr   = e_addr;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, ".instr"},  {16'd0, bus.id_instruction}, {16'd0, e.instr});
      check_val({tag, ".pcn"},    {16'd0, bus.id_pc_next},     {16'd0, e.pcn});
      check_val({tag, ".valid"},  {31'd0, bus.id_valid},       {31'd0, e.valid});
      check_val({tag, ".stop"},   {31'd0, bus.pc_stop},        {31'd0, e.stop});
      check_val({tag, ".halted"}, {31'd0, bus.halted},         {31'd0, e.halted});
      check_val({tag, ".addr"},   {16'd0, bus.imem_addr},      {16'd0, e.addr});
    end
  endtask

  // One clock: drive controls, queue the expected post-edge state, compare.
  task automatic step(input string tag, input logic br, input logic [15:0] tgt,
                      input logic hold, input logic [15:0] e_instr,
                      input logic [15:0] e_pcn, input logic e_valid,
                      input logic e_stop, input logic e_halted,
                      input logic [15:0] e_addr);
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.hazard_hold   = hold;
    push_exp(e_instr, e_pcn, e_valid, e_stop, e_halted, e_addr);
    @(posedge clock);
    #1;
    compare_out(tag);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    reset = 1'b0;
    push_exp(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    #2;
    compare_out(tag);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h1000 | {4'h0, i[11:0]};
    end
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'h2345;
    mem[16'h0004] = 16'h3456;
    mem[16'h0006] = 16'hF000;
    mem[16'h0200] = 16'hF123;

    reset             = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.hazard_hold   = 1'b0;
    #12;
    push_exp(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    compare_out("reset");
    #8;
    reset = 1'b1;

    // Sequential fetch out of reset.
    step("fetch0", 1'b0, 16'h0000, 1'b0, 16'h1234, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0002);
    step("fetch1", 1'b0, 16'h0000, 1'b0, 16'h2345, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0004);
    // Hazard hold for two cycles, then resume at 0004.
    step("hold0",  1'b0, 16'h0000, 1'b1, 16'h2345, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0004);
    step("hold1",  1'b0, 16'h0000, 1'b1, 16'h2345, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0004);
    step("resume", 1'b0, 16'h0000, 1'b0, 16'h3456, 16'h0006, 1'b1, 1'b0, 1'b0, 16'h0006);
    // Branch wins over hold; odd target is aligned down.
    step("br_hold", 1'b1, 16'h0041, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040);
    step("br_odd",  1'b1, 16'h0007, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0006);
    // HALT at 0006 and drain of three unheld cycles (one hold in between).
    step("halt_f",  1'b0, 16'h0000, 1'b0, 16'hF000, 16'h0008, 1'b1, 1'b1, 1'b0, 16'h0006);
    step("drain1",  1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0006);
    step("drain_h", 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0006);
    step("drain2",  1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0006);
    step("drain3",  1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0006);
    step("hlt_br",  1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0006);
    step("hlt_hold", 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0006);
    async_reset("rst_halted");

    // Wrong-path HALT cancelled by a branch.
    step("wp_br",   1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0200);
    step("wp_halt", 1'b0, 16'h0000, 1'b0, 16'hF123, 16'h0202, 1'b1, 1'b1, 1'b0, 16'h0200);
    step("wp_redir", 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0100);
    step("wp_run0", 1'b0, 16'h0000, 1'b0, 16'h1100, 16'h0102, 1'b1, 1'b0, 1'b0, 16'h0102);
    step("wp_run1", 1'b0, 16'h0000, 1'b0, 16'h1102, 16'h0104, 1'b1, 1'b0, 1'b0, 16'h0104);

    // PC wrap from FFFE to 0000.
    step("wr_br",   1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFE);
    step("wrap",    1'b0, 16'h0000, 1'b0, 16'h1FFE, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    step("wr_next", 1'b0, 16'h0000, 1'b0, 16'h1234, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0002);

    // Async reset while in HALT_PEND.
    step("hp_br",   1'b1, 16'h0006, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0006);
    step("hp_halt", 1'b0, 16'h0000, 1'b0, 16'hF000, 16'h0008, 1'b1, 1'b1, 1'b0, 16'h0006);
    async_reset("rst_pend");
    step("post_rst", 1'b0, 16'h0000, 1'b0, 16'h1234, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0002);

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
